// File: rtl/vga_fb_fetch.sv
// AXI4 read-burst sequencer streaming the active VGA frame buffer into the pixel tx FIFO.
// Optional macro VGA_FETCH_4K_SPLIT_EN clips bursts so none crosses a 4 KB boundary.
module vga_fb_fetch #(
  parameter int unsigned FIFO_DEPTH = 512,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic                          en_i,
  input  logic                          vbse_i,
  input  logic [ADDR_WIDTH-1:0]         fbba1_i,
  input  logic [ADDR_WIDTH-1:0]         fbba2_i,
  input  logic [31:0]                   frame_beats_i,
  input  logic [7:0]                    brulen_i,
  input  logic [$clog2(FIFO_DEPTH):0]   fifo_free_i,
  output logic [ADDR_WIDTH-1:0]         araddr_o,
  output logic [7:0]                    arlen_o,
  output logic                          arvalid_o,
  input  logic                          arready_i,
  input  logic                          rvalid_i,
  input  logic                          rlast_i,
  input  logic [1:0]                    rresp_i,
  output logic                          rready_o,
  output logic                          push_valid_o,
  output logic                          cfb_o,
  output logic                          vbsirq_o,
  output logic                          frame_done_o,
  output logic                          err_o
);

  typedef enum logic [2:0] {
    StIdle,
    StChk,
    StAr,
    StR,
    StDrain
  } state_e;

  state_e                  state_q, state_d;
  logic                    cfb_q, cfb_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [31:0]             rem_q, rem_d;
  logic [8:0]              blen_q, blen_d;
  logic [ADDR_WIDTH-1:0]   araddr_q, araddr_d;
  logic [7:0]              arlen_q, arlen_d;
  logic [31:0]             cur_len;
`ifdef VGA_FETCH_4K_SPLIT_EN
  logic [31:0]             page_left;
`endif

  // Length of the next burst: configured burst size, clipped to what is left of the frame.
  always_comb begin
    cur_len = (32'(blen_q) < rem_q) ? 32'(blen_q) : rem_q;
`ifdef VGA_FETCH_4K_SPLIT_EN
    page_left = 32'd512 - 32'(addr_q[11:3]);
    if (page_left < cur_len) begin
      cur_len = page_left;
    end
`endif
  end

  always_comb begin
    state_d      = state_q;
    cfb_d        = cfb_q;
    addr_d       = addr_q;
    rem_d        = rem_q;
    blen_d       = blen_q;
    araddr_d     = araddr_q;
    arlen_d      = arlen_q;
    arvalid_o    = 1'b0;
    rready_o     = 1'b0;
    push_valid_o = 1'b0;
    vbsirq_o     = 1'b0;
    frame_done_o = 1'b0;
    err_o        = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (en_i && (frame_beats_i != 32'd0)) begin
          addr_d  = cfb_q ? fbba2_i : fbba1_i;
          rem_d   = frame_beats_i;
          blen_d  = {1'b0, brulen_i} + 9'd1;
          state_d = StChk;
        end else if (!en_i) begin
          rem_d = 32'd0;
        end
      end
      StChk: begin
        if (!en_i) begin
          rem_d   = 32'd0;
          state_d = StIdle;
        end else if (32'(fifo_free_i) >= cur_len) begin
          araddr_d = addr_q;
          arlen_d  = 8'(cur_len - 32'd1);
          state_d  = StAr;
        end
      end
      StAr: begin
        // Once raised, AR stays up until accepted regardless of en_i.
        arvalid_o = 1'b1;
        if (arready_i) begin
          state_d = StR;
        end
      end
      StR: begin
        rready_o     = 1'b1;
        push_valid_o = rvalid_i && en_i;
        err_o        = rvalid_i && (rresp_i != 2'b00);
        if (!en_i) begin
          // Disabled mid-burst: finish the burst without pushing or advancing.
          state_d = (rvalid_i && rlast_i) ? StIdle : StDrain;
        end else if (rvalid_i) begin
          addr_d = addr_q + ADDR_WIDTH'(8);
          if (rem_q != 32'd0) begin
            rem_d = rem_q - 32'd1;
          end
          if (rlast_i) begin
            if (rem_q <= 32'd1) begin
              frame_done_o = 1'b1;
              if (vbse_i) begin
                cfb_d    = ~cfb_q;
                vbsirq_o = 1'b1;
              end
              state_d = StIdle;
            end else begin
              state_d = StChk;
            end
          end
        end
      end
      StDrain: begin
        rready_o = 1'b1;
        if (rvalid_i && rlast_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= StIdle;
      cfb_q    <= 1'b0;
      addr_q   <= '0;
      rem_q    <= 32'd0;
      blen_q   <= 9'd0;
      araddr_q <= '0;
      arlen_q  <= 8'd0;
    end else begin
      state_q  <= state_d;
      cfb_q    <= cfb_d;
      addr_q   <= addr_d;
      rem_q    <= rem_d;
      blen_q   <= blen_d;
      araddr_q <= araddr_d;
      arlen_q  <= arlen_d;
    end
  end

  assign araddr_o = araddr_q;
  assign arlen_o  = arlen_q;
  assign cfb_o    = cfb_q;

endmodule

// File: tb/tb_vga_fb_fetch.sv
// Scoreboard bench for vga_fb_fetch: expected AR requests and frame ends are queued by the
// stimulus; a monitor pops and compares as the DUT presents them.
module tb_vga_fb_fetch;

  localparam int unsigned FD = 512;
  localparam int unsigned AW = 32;

  logic          clk, rst_n, en, vbse;
  logic [AW-1:0] fbba1, fbba2, araddr;
  logic [31:0]   frame_beats;
  logic [7:0]    brulen, arlen;
  logic [9:0]    fifo_free;
  logic          arvalid, arready, rvalid, rlast, rready, push_valid;
  logic [1:0]    rresp;
  logic          cfb, vbsirq, frame_done, err;

  vga_fb_fetch #(.FIFO_DEPTH(FD), .ADDR_WIDTH(AW)) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .en_i         (en),
    .vbse_i       (vbse),
    .fbba1_i      (fbba1),
    .fbba2_i      (fbba2),
    .frame_beats_i(frame_beats),
    .brulen_i     (brulen),
    .fifo_free_i  (fifo_free),
    .araddr_o     (araddr),
    .arlen_o      (arlen),
    .arvalid_o    (arvalid),
    .arready_i    (arready),
    .rvalid_i     (rvalid),
    .rlast_i      (rlast),
    .rresp_i      (rresp),
    .rready_o     (rready),
    .push_valid_o (push_valid),
    .cfb_o        (cfb),
    .vbsirq_o     (vbsirq),
    .frame_done_o (frame_done),
    .err_o        (err)
  );

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
  } ar_t;
  typedef struct {
    int   beats;
    logic vbs;
  } fd_t;

  ar_t ar_exp[$];
  fd_t fd_exp[$];
  ar_t ar_e;
  fd_t fd_e;

  int checks = 0, failures = 0;
  int push_total = 0, push_since = 0, fd_cnt = 0, err_cnt = 0, ar_cnt = 0;
  int rbeat_total = 0, err_at = -1, sl_left = 0;
  int p0, t0, e0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_fd(input int target, input int budget);
    int n;
    n = 0;
    while (fd_cnt < target && n < budget) begin
      @(negedge clk);
      #3;
      n++;
    end
    if (fd_cnt < target) begin
      checks++;
      failures++;
      $display("FAIL frame_done_timeout: got %0d frames, required %0d", fd_cnt, target);
    end
  endtask

  task automatic push_ar(input logic [31:0] a, input logic [7:0] l);
    ar_t x;
    x.addr = a;
    x.len  = l;
    ar_exp.push_back(x);
  endtask

  task automatic push_fd(input int b, input logic v);
    fd_t x;
    x.beats = b;
    x.vbs   = v;
    fd_exp.push_back(x);
  endtask

  // AXI slave: after an AR handshake returns len+1 back-to-back beats.
  initial begin
    rvalid = 1'b0;
    rlast  = 1'b0;
    rresp  = 2'b00;
    forever begin
      @(negedge clk);
      if (sl_left > 0) begin
        rbeat_total++;
        rvalid = 1'b1;
        rlast  = (sl_left == 1);
        rresp  = (rbeat_total == err_at) ? 2'b10 : 2'b00;
        sl_left--;
      end else begin
        rvalid = 1'b0;
        rlast  = 1'b0;
        rresp  = 2'b00;
      end
      #1;
      if (arvalid && arready) sl_left = int'(arlen) + 1;
    end
  end

  // Monitor
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (arvalid && arready) begin
        ar_cnt++;
        if (ar_exp.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_ar: got addr 0x%0h len %0d, required no request", araddr, arlen);
        end else begin
          ar_e = ar_exp.pop_front();
          check("ar_addr", 64'(araddr), 64'(ar_e.addr));
          check("ar_len", 64'(arlen), 64'(ar_e.len));
        end
      end
      if (rvalid) check("rready_on_beat", 64'(rready), 64'd1);
      if (push_valid) begin
        push_total++;
        push_since++;
      end
      if (err) begin
        err_cnt++;
        check("err_beat_pushed", 64'(push_valid), 64'd1);
      end
      if (frame_done) begin
        fd_cnt++;
        if (fd_exp.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_frame_done: got pulse, required none");
        end else begin
          fd_e = fd_exp.pop_front();
          check("frame_beats_pushed", 64'(push_since), 64'(fd_e.beats));
          check("vbsirq_with_fd", 64'(vbsirq), 64'(fd_e.vbs));
        end
        push_since = 0;
      end else if (vbsirq) begin
        checks++;
        failures++;
        $display("FAIL vbsirq_alone: got 1, required 0 without frame_done");
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: got no end of test, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; en = 1'b0; vbse = 1'b0;
    fbba1 = 32'h1000; fbba2 = 32'h8000; frame_beats = 32'd0;
    brulen = 8'd15; fifo_free = 10'd512; arready = 1'b1;

    repeat (3) @(negedge clk);
    #3;
    check("rst_arvalid", 64'(arvalid), 64'd0);
    check("rst_rready", 64'(rready), 64'd0);
    check("rst_push", 64'(push_valid), 64'd0);
    check("rst_cfb", 64'(cfb), 64'd0);
    check("rst_araddr", 64'(araddr), 64'd0);
    check("rst_arlen", 64'(arlen), 64'd0);
    check("rst_fd_irq_err", 64'({frame_done, vbsirq, err}), 64'd0);
    @(negedge clk) rst_n = 1'b1;

    // Empty frame: enabled but nothing to fetch.
    @(negedge clk) en = 1'b1;
    repeat (10) @(negedge clk);
    #3;
    check("zero_frame_no_ar", 64'(ar_cnt), 64'd0);
    @(negedge clk) en = 1'b0;

    // 40-beat frame twice, burst 16, with enable-to-AR latency.
    @(negedge clk);
    frame_beats = 32'd40;
    push_ar(32'h1000, 8'd15); push_ar(32'h1080, 8'd15); push_ar(32'h1100, 8'd7);
    push_ar(32'h1000, 8'd15); push_ar(32'h1080, 8'd15); push_ar(32'h1100, 8'd7);
    push_fd(40, 1'b0); push_fd(40, 1'b0);
    push_since = 0;
    p0 = push_total;
    t0 = fd_cnt;
    en = 1'b1;
    @(negedge clk);
    #3 check("latency_chk", 64'(arvalid), 64'd0);
    @(negedge clk);
    #3 check("latency_ar", 64'(arvalid), 64'd1);
    wait_fd(t0 + 2, 400);
    @(negedge clk) en = 1'b0;
    repeat (3) @(negedge clk);
    #3;
    check("f40_pushes", 64'(push_total - p0), 64'd80);
    check("f40_ar_left", 64'(ar_exp.size()), 64'd0);
    check("f40_cfb", 64'(cfb), 64'd0);

    // FIFO too full for a 16-beat burst, then room appears.
    @(negedge clk);
    frame_beats = 32'd16;
    fifo_free = 10'd10;
    p0 = ar_cnt;
    t0 = fd_cnt;
    en = 1'b1;
    repeat (10) @(negedge clk);
    #3;
    check("fifo_block_no_ar", 64'(ar_cnt - p0), 64'd0);
    @(negedge clk);
    push_ar(32'h1000, 8'd15);
    push_fd(16, 1'b0);
    fifo_free = 10'd16;
    wait_fd(t0 + 1, 100);
    @(negedge clk) en = 1'b0;
    fifo_free = 10'd512;

    // Double-buffer swap on two consecutive frames.
    @(negedge clk);
    vbse = 1'b1;
    push_ar(32'h1000, 8'd15); push_ar(32'h8000, 8'd15);
    push_fd(16, 1'b1); push_fd(16, 1'b1);
    push_since = 0;
    t0 = fd_cnt;
    en = 1'b1;
    wait_fd(t0 + 1, 100);
    @(negedge clk);
    #3 check("swap_cfb_1", 64'(cfb), 64'd1);
    wait_fd(t0 + 2, 100);
    @(negedge clk) en = 1'b0;
    @(negedge clk);
    #3 check("swap_cfb_0", 64'(cfb), 64'd0);
    check("swap_ar_left", 64'(ar_exp.size()), 64'd0);
    vbse = 1'b0;

    // Disable after 3 beats: remaining beats drained without pushes.
    @(negedge clk);
    fbba1 = 32'h2000;
    frame_beats = 32'd32;
    push_ar(32'h2000, 8'd15);
    push_since = 0;
    p0 = push_total;
    t0 = fd_cnt;
    en = 1'b1;
    for (int n = 0; n < 100 && push_total < p0 + 3; n++) begin
      @(negedge clk);
      #3;
    end
    @(negedge clk) en = 1'b0;
    repeat (30) @(negedge clk);
    #3;
    check("drain_pushes", 64'(push_total - p0), 64'd3);
    check("drain_beats_left", 64'(sl_left), 64'd0);
    check("drain_idle_rready", 64'(rready), 64'd0);
    check("drain_no_ar", 64'(arvalid), 64'd0);
    check("drain_ar_left", 64'(ar_exp.size()), 64'd0);
    check("drain_no_fd", 64'(fd_cnt - t0), 64'd0);

    // SLVERR on beat 5 of a 16-beat frame.
    @(negedge clk);
    fbba1 = 32'h3000;
    frame_beats = 32'd16;
    push_ar(32'h3000, 8'd15);
    push_fd(16, 1'b0);
    push_since = 0;
    err_at = rbeat_total + 5;
    e0 = err_cnt;
    t0 = fd_cnt;
    en = 1'b1;
    wait_fd(t0 + 1, 100);
    @(negedge clk) en = 1'b0;
    repeat (3) @(negedge clk);
    #3 check("err_pulses", 64'(err_cnt - e0), 64'd1);

    // Base just below a 4 KB boundary.
    @(negedge clk);
    fbba1 = 32'h0FC0;
    frame_beats = 32'd32;
`ifdef VGA_FETCH_4K_SPLIT_EN
    push_ar(32'h0FC0, 8'd7); push_ar(32'h1000, 8'd15); push_ar(32'h1080, 8'd7);
`else
    push_ar(32'h0FC0, 8'd15); push_ar(32'h1040, 8'd15);
`endif
    push_fd(32, 1'b0);
    push_since = 0;
    t0 = fd_cnt;
    en = 1'b1;
    wait_fd(t0 + 1, 200);
    @(negedge clk) en = 1'b0;
    repeat (3) @(negedge clk);
    #3 check("page_ar_left", 64'(ar_exp.size()), 64'd0);
    check("fd_exp_left", 64'(fd_exp.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
